// File: rtl/coef_load_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : coef_load_ctrl
//  Description : FIR coefficient load sequencer. Packs byte pairs from the
//                UART receiver into 12-bit coefficients and writes them in
//                order to the coefficient bank, aborting a stalled load.
//  Revision    : 1.0 - initial release
// ============================================================================
module coef_load_ctrl #(
    parameter int N_COEF      = 16,
    parameter int TIMEOUT_CYC = 1_000_000
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      pulsador_carga_coef_i,
    input  logic [7:0]                rx_data_i,
    input  logic                      rx_valid_i,
    output logic                      coef_wr_o,
    output logic [$clog2(N_COEF)-1:0] coef_addr_o,
    output logic [11:0]               coef_data_o,
    output logic                      en_recepcion_o,
    output logic                      fin_block_coef_o,
    output logic                      en_fir_o,
    output logic                      err_o
);

    localparam int c_ADDR_W = $clog2(N_COEF);
    localparam int c_TMO_W  = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    localparam logic [c_ADDR_W-1:0] c_LAST_IDX = c_ADDR_W'(N_COEF - 1);
    localparam logic [c_TMO_W-1:0]  c_TMO_LAST = c_TMO_W'(TIMEOUT_CYC - 1);

    localparam logic [1:0] c_IDLE    = 2'd0;
    localparam logic [1:0] c_WAIT_LO = 2'd1;
    localparam logic [1:0] c_WAIT_HI = 2'd2;

    logic [1:0]          r_state;
    logic                r_req_d;
    logic [c_ADDR_W-1:0] r_idx;
    logic [7:0]          r_lo;
    logic [c_TMO_W-1:0]  r_tmo_cnt;
    logic                r_wr;
    logic                r_fin;
    logic [c_ADDR_W-1:0] r_addr;
    logic [11:0]         r_data;
    logic                r_en_fir;
    logic                r_err;

    logic [1:0] w_state_nxt;
    logic       w_req_rise;
    logic       w_tmo_hit;
    logic       w_start;
    logic       w_latch_lo;
    logic       w_wr;
    logic       w_fin;
    logic       w_timeout;
    logic       w_unused_hi;

    assign w_req_rise  = pulsador_carga_coef_i & ~r_req_d;
    assign w_tmo_hit   = (r_tmo_cnt == c_TMO_LAST);
    // Upper nibble of the high byte carries no coefficient information.
    assign w_unused_hi = ^rx_data_i[7:4];

    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_latch_lo  = 1'b0;
        w_wr        = 1'b0;
        w_fin       = 1'b0;
        w_timeout   = 1'b0;
        case (r_state)
            c_IDLE: begin
                // A byte arriving alongside the request edge is dropped.
                if (w_req_rise) begin
                    w_state_nxt = c_WAIT_LO;
                    w_start     = 1'b1;
                end
            end
            c_WAIT_LO: begin
                if (rx_valid_i) begin
                    w_state_nxt = c_WAIT_HI;
                    w_latch_lo  = 1'b1;
                end else if (w_tmo_hit) begin
                    w_state_nxt = c_IDLE;
                    w_timeout   = 1'b1;
                end
            end
            c_WAIT_HI: begin
                if (rx_valid_i) begin
                    w_wr = 1'b1;
                    if (r_idx == c_LAST_IDX) begin
                        w_state_nxt = c_IDLE;
                        w_fin       = 1'b1;
                    end else begin
                        w_state_nxt = c_WAIT_LO;
                    end
                end else if (w_tmo_hit) begin
                    w_state_nxt = c_IDLE;
                    w_timeout   = 1'b1;
                end
            end
            default: w_state_nxt = c_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_req_d   <= 1'b0;
            r_idx     <= '0;
            r_lo      <= '0;
            r_tmo_cnt <= '0;
            r_wr      <= 1'b0;
            r_fin     <= 1'b0;
            r_addr    <= '0;
            r_data    <= '0;
            r_en_fir  <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_req_d <= pulsador_carga_coef_i;
            r_wr    <= w_wr;
            r_fin   <= w_fin;

            if (w_start) begin
                r_idx     <= '0;
                r_tmo_cnt <= '0;
                r_err     <= 1'b0;
                r_en_fir  <= 1'b0;
            end else if (r_state != c_IDLE) begin
                // Idle-gap counter: any accepted byte restarts it.
                if (rx_valid_i) begin
                    r_tmo_cnt <= '0;
                end else begin
                    r_tmo_cnt <= r_tmo_cnt + c_TMO_W'(1);
                end
            end

            if (w_latch_lo) begin
                r_lo <= rx_data_i;
            end

            if (w_wr) begin
                r_addr <= r_idx;
                r_data <= {rx_data_i[3:0], r_lo};
                r_idx  <= r_idx + c_ADDR_W'(1);
            end

            if (w_fin) begin
                r_en_fir <= 1'b1;
            end

            if (w_timeout) begin
                r_err <= 1'b1;
            end
        end
    end

    assign coef_wr_o        = r_wr;
    assign coef_addr_o      = r_addr;
    assign coef_data_o      = r_data;
    assign en_recepcion_o   = (r_state != c_IDLE);
    assign fin_block_coef_o = r_fin;
    assign en_fir_o         = r_en_fir;
    assign err_o            = r_err;

endmodule
`default_nettype wire

// File: tb/tb_coef_load_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_coef_load_ctrl
//  Description : Randomised self-checking bench for coef_load_ctrl against a
//                byte-counting reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_coef_load_ctrl;

    localparam int c_N_COEF = 16;
    localparam int c_TMO    = 50;

    logic        clk = 1'b0;
    logic        rst;
    logic        req;
    logic        rx_valid;
    logic [7:0]  rx_data;

    logic        w_coef_wr;
    logic [3:0]  w_coef_addr;
    logic [11:0] w_coef_data;
    logic        w_en_rx;
    logic        w_fin;
    logic        w_en_fir;
    logic        w_err;

    int n_checks = 0;
    int n_errors = 0;

    coef_load_ctrl #(
        .N_COEF      (c_N_COEF),
        .TIMEOUT_CYC (c_TMO)
    ) u_dut (
        .clk_i                 (clk),
        .rst_i                 (rst),
        .pulsador_carga_coef_i (req),
        .rx_data_i             (rx_data),
        .rx_valid_i            (rx_valid),
        .coef_wr_o             (w_coef_wr),
        .coef_addr_o           (w_coef_addr),
        .coef_data_o           (w_coef_data),
        .en_recepcion_o        (w_en_rx),
        .fin_block_coef_o      (w_fin),
        .en_fir_o              (w_en_fir),
        .err_o                 (w_err)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Reference model: a load is a count of accepted bytes; even bytes are
    // low halves, odd bytes complete coefficient bytes/2.
    bit        m_loading, m_prev_req, m_wr, m_fin, m_fir, m_err;
    int        m_bytes, m_idle;
    logic [7:0]  m_lo;
    logic [3:0]  m_addr;
    logic [11:0] m_data;

    int          cyc = 0;
    int          last_byte_cyc = 0;
    int          err_rise_cyc = -1;
    bit          prev_err = 1'b0;
    logic [15:0] wlog[$];
    int          wcyc[$];
    int          fin_cnt = 0;

    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            m_loading = 0; m_prev_req = 0; m_wr = 0; m_fin = 0; m_fir = 0; m_err = 0;
            m_bytes = 0; m_idle = 0; m_lo = '0; m_addr = '0; m_data = '0;
        end else begin
            m_wr  = 0;
            m_fin = 0;
            if (!m_loading) begin
                if (req && !m_prev_req) begin
                    m_loading = 1; m_bytes = 0; m_idle = 0; m_err = 0; m_fir = 0;
                end
            end else if (rx_valid) begin
                last_byte_cyc = cyc;
                m_idle = 0;
                if (m_bytes % 2 == 0) begin
                    m_lo = rx_data;
                end else begin
                    m_wr   = 1;
                    m_addr = 4'(m_bytes / 2);
                    m_data = {rx_data[3:0], m_lo};
                    if (m_bytes / 2 == c_N_COEF - 1) begin
                        m_loading = 0; m_fin = 1; m_fir = 1;
                    end
                end
                m_bytes++;
            end else if (m_idle == c_TMO - 1) begin
                m_loading = 0;
                m_err     = 1;
            end else begin
                m_idle++;
            end
            m_prev_req = req;
        end
        #1;
        check_val("wr",    32'(w_coef_wr),   32'(m_wr));
        check_val("fin",   32'(w_fin),       32'(m_fin));
        check_val("en_rx", 32'(w_en_rx),     32'(m_loading));
        check_val("en_fir",32'(w_en_fir),    32'(m_fir));
        check_val("err",   32'(w_err),       32'(m_err));
        check_val("addr",  32'(w_coef_addr), 32'(m_addr));
        check_val("data",  32'(w_coef_data), 32'(m_data));
        if (w_coef_wr) begin
            wlog.push_back({w_coef_addr, w_coef_data});
            wcyc.push_back(cyc);
        end
        if (w_fin) fin_cnt++;
        if (w_err && !prev_err) err_rise_cyc = cyc;
        prev_err = w_err;
    end

    task automatic tick(input logic v, input logic [7:0] d);
        rx_valid = v;
        rx_data  = d;
        @(negedge clk);
    endtask

    task automatic send(input logic [7:0] b, input int gapmax);
        tick(1'b1, b);
        repeat ($urandom_range(gapmax, 0)) tick(1'b0, 8'h00);
    endtask

    task automatic clear_log();
        wlog.delete();
        wcyc.delete();
        fin_cnt = 0;
        err_rise_cyc = -1;
    endtask

    task automatic request();
        req = 1'b0;
        tick(1'b0, 8'h00);
        req = 1'b1;
        tick(1'b0, 8'h00);
    endtask

    task automatic random_load(input int gapmax);
        for (int k = 0; k < 2 * c_N_COEF; k++) send(8'($urandom), gapmax);
        repeat (3) tick(1'b0, 8'h00);
    endtask

    initial begin
        logic [7:0]  bytes [0:31];
        logic [15:0] exp_w;

        rst = 1'b1; req = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
        @(negedge clk);
        tick(1'b0, 8'h00);
        tick(1'b0, 8'h00);
        rst = 1'b0;
        check_val("rst_addr", 32'(w_coef_addr), 32'd0);
        check_val("rst_data", 32'(w_coef_data), 32'd0);
        check_val("rst_en_fir", 32'(w_en_fir), 32'd0);

        // Bytes while idle
        clear_log();
        for (int k = 0; k < 4; k++) send(8'($urandom), 1);
        check_val("idle_writes", 32'(wlog.size()), 32'd0);

        // Full load with the fixed pattern, request held high throughout
        clear_log();
        request();
        for (int i = 0; i < c_N_COEF; i++) begin
            send(8'h10 + 8'(i), 2);
            send(8'hF0 | 8'(i), 2);
        end
        repeat (3) tick(1'b0, 8'h00);
        check_val("full_count", 32'(wlog.size()), 32'd16);
        for (int i = 0; i < wlog.size() && i < c_N_COEF; i++) begin
            exp_w = 16'((i << 12) | (i << 8) | (16 + i));
            check_val("full_word", 32'(wlog[i]), 32'(exp_w));
        end
        check_val("full_fin", 32'(fin_cnt), 32'd1);
        check_val("full_en_fir", 32'(w_en_fir), 32'd1);
        check_val("full_err", 32'(w_err), 32'd0);
        for (int k = 0; k < 10; k++) send(8'($urandom), 1);
        check_val("held_count", 32'(wlog.size()), 32'd16);
        check_val("held_en_rx", 32'(w_en_rx), 32'd0);

        // Request edge with a byte in the same cycle, then back-to-back bytes
        clear_log();
        req = 1'b0;
        tick(1'b0, 8'h00);
        req = 1'b1;
        tick(1'b1, 8'hAA);
        for (int k = 0; k < 32; k++) begin
            bytes[k] = 8'($urandom);
            tick(1'b1, bytes[k]);
        end
        repeat (3) tick(1'b0, 8'h00);
        check_val("b2b_count", 32'(wlog.size()), 32'd16);
        for (int i = 0; i < wlog.size() && i < c_N_COEF; i++) begin
            exp_w = {4'(i), bytes[2*i+1][3:0], bytes[2*i]};
            check_val("b2b_word", 32'(wlog[i]), 32'(exp_w));
        end
        for (int i = 1; i < wcyc.size(); i++)
            check_val("b2b_spacing", 32'(wcyc[i] - wcyc[i-1]), 32'd2);
        check_val("b2b_fin", 32'(fin_cnt), 32'd1);

        // Second request edge during a load is ignored
        clear_log();
        request();
        for (int k = 0; k < 6; k++) send(8'($urandom), 2);
        req = 1'b0;
        tick(1'b0, 8'h00);
        req = 1'b1;
        tick(1'b0, 8'h00);
        for (int k = 6; k < 32; k++) send(8'($urandom), 2);
        repeat (3) tick(1'b0, 8'h00);
        check_val("edge2_count", 32'(wlog.size()), 32'd16);
        for (int i = 0; i < wlog.size() && i < c_N_COEF; i++)
            check_val("edge2_addr", 32'(wlog[i][15:12]), 32'(i));
        check_val("edge2_fin", 32'(fin_cnt), 32'd1);

        // Timeout after two coefficients and one low byte
        clear_log();
        request();
        for (int k = 0; k < 5; k++) send(8'($urandom), 2);
        repeat (60) tick(1'b0, 8'h00);
        check_val("tmo_count", 32'(wlog.size()), 32'd2);
        for (int i = 0; i < wlog.size() && i < 2; i++)
            check_val("tmo_addr", 32'(wlog[i][15:12]), 32'(i));
        check_val("tmo_latency", 32'(err_rise_cyc - last_byte_cyc), 32'(c_TMO));
        check_val("tmo_err", 32'(w_err), 32'd1);
        check_val("tmo_en_fir", 32'(w_en_fir), 32'd0);
        check_val("tmo_en_rx", 32'(w_en_rx), 32'd0);
        check_val("tmo_fin", 32'(fin_cnt), 32'd0);
        request();
        check_val("tmo_clear", 32'(w_err), 32'd0);
        clear_log();
        random_load(2);
        check_val("tmo_reload_fin", 32'(fin_cnt), 32'd1);

        // Reset in the middle of a load
        clear_log();
        request();
        req = 1'b0;
        for (int k = 0; k < 7; k++) send(8'($urandom), 1);
        rst = 1'b1;
        tick(1'b0, 8'h00);
        rst = 1'b0;
        check_val("mrst_en_rx", 32'(w_en_rx), 32'd0);
        check_val("mrst_err", 32'(w_err), 32'd0);
        check_val("mrst_addr", 32'(w_coef_addr), 32'd0);
        check_val("mrst_data", 32'(w_coef_data), 32'd0);
        clear_log();
        request();
        random_load(1);
        check_val("mrst_count", 32'(wlog.size()), 32'd16);
        if (wlog.size() > 0) check_val("mrst_first_addr", 32'(wlog[0][15:12]), 32'd0);

        // Random loads with stray idle bytes
        for (int r = 0; r < 4; r++) begin
            clear_log();
            req = 1'b0;
            repeat ($urandom_range(3, 0)) send(8'($urandom), 1);
            request();
            random_load(3);
            check_val("rand_count", 32'(wlog.size()), 32'd16);
            check_val("rand_fin", 32'(fin_cnt), 32'd1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
